// File: rtl/gray_pkg.sv
// Shared definitions for the Gray/binary pipelined converter.
//   MODE_G2B / MODE_B2G : encodings of the per-beat direction select
//   chunk_bits()        : bits resolved per pipeline stage, ceil(WIDTH/STAGES)
//   g2b_ref()           : plain MSB-first Gray-to-binary prefix XOR on a 64-bit word
package gray_pkg;

    localparam logic MODE_G2B = 1'b0;
    localparam logic MODE_B2G = 1'b1;

    function automatic int chunk_bits(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    // Narrower words zero-extended into 64 bits convert correctly, because
    // leading zeros leave the running XOR untouched.
    function automatic logic [63:0] g2b_ref(input logic [63:0] word);
        logic [63:0] b;
        b[63] = word[63];
        for (int i = 62; i >= 0; i--) begin
            b[i] = b[i+1] ^ word[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_bin_stage.sv
// One pipeline stage of the Gray/binary converter.
//   clk, rst         : clock, asynchronous active-high reset
//   adv_i            : load enable (stage is empty or its beat is leaving)
//   vld_i/data_i/mode_i : beat from the previous stage (or the input port)
//   vld_o/data_o/mode_o : registered beat held by this stage
// In G2B mode the stage resolves bits HI..LO of the word; bits above HI
// arrive already resolved to binary, bits below LO pass through as Gray.
// The first stage also performs the whole B2G conversion; later stages
// pass B2G words unchanged. An empty chunk (HI < LO) makes a pure delay.
module gray_bin_stage
    import gray_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LO    = 0,
    parameter int HI    = 7,
    parameter bit FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             mode_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o,
    output logic             mode_o
);

    logic             vld_q;
    logic             mode_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             carry;

    // Walking MSB-first, carry always holds the binary value of the bit just
    // above the current one, so the chunk's carry-in is the resolved LSB of
    // the previous chunk without any out-of-range indexing.
    always_comb begin
        data_d = data_i;
        carry  = 1'b0;
        if (mode_i == MODE_B2G) begin
            if (FIRST) begin
                data_d = data_i ^ (data_i >> 1);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (i <= HI && i >= LO) begin
                    data_d[i] = carry ^ data_i[i];
                end
                carry = data_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            mode_q <= 1'b0;
        end else if (adv_i) begin
            vld_q <= vld_i;
            if (vld_i) begin
                data_q <= data_d;
                mode_q <= mode_i;
            end
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign mode_o = mode_q;

endmodule

// File: rtl/gray_bin_conv_pipe.sv
// Pipelined Gray<->binary converter with valid/ready streaming.
//   clk, rst                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_mode  : input beat (mode 0 = G2B, 1 = B2G)
//   out_valid/out_ready/out_data/out_mode : registered result beat
// STAGES stages each resolve a ceil(WIDTH/STAGES)-bit chunk, MSB-first.
// Latency is STAGES cycles in either mode; throughput one beat per cycle.
module gray_bin_conv_pipe
    import gray_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode
);

    localparam int C = chunk_bits(WIDTH, STAGES);

    // Index 0 is the input port; index k+1 is the register of stage k.
    logic [STAGES:0]  vld;
    logic [STAGES:0]  mode;
    logic [WIDTH-1:0] data [STAGES+1];
    // adv[k] is the load enable of stage k; adv[STAGES] is the consumer.
    logic [STAGES:0]  adv;

    assign vld[0]  = in_valid;
    assign mode[0] = in_mode;
    assign data[0] = in_data;

    // A stage may load when it is empty or when its own beat moves on, so a
    // full pipe with out_ready high moves every beat on the same edge.
    always_comb begin
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !vld[k+1] || adv[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI = WIDTH - 1 - k * C;
        localparam int LO = (HI - C + 1 > 0) ? (HI - C + 1) : 0;

        gray_bin_stage #(
            .WIDTH (WIDTH),
            .LO    (LO),
            .HI    (HI),
            .FIRST (k == 0)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .adv_i  (adv[k]),
            .vld_i  (vld[k]),
            .data_i (data[k]),
            .mode_i (mode[k]),
            .vld_o  (vld[k+1]),
            .data_o (data[k+1]),
            .mode_o (mode[k+1])
        );
    end

    assign in_ready  = adv[0] & ~rst;
    assign out_valid = vld[STAGES];
    assign out_data  = data[STAGES];
    assign out_mode  = mode[STAGES];

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
module tb_gray_bin_conv_pipe;
    import gray_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    // Main DUT: WIDTH=8, STAGES=3
    logic       in_valid_a = 1'b0;
    logic       in_ready_a;
    logic [7:0] in_data_a  = 8'h00;
    logic       in_mode_a  = 1'b0;
    logic       out_valid_a;
    logic       out_ready_a = 1'b1;
    logic [7:0] out_data_a;
    logic       out_mode_a;

    // Shared stimulus for the small/edge instances (always out_ready=1)
    logic        e_valid = 1'b0;
    logic [63:0] e_data  = 64'h0;
    logic        e_mode  = 1'b0;
    logic        ready_b, ov_b, om_b;
    logic [3:0]  od_b;
    logic        ready_c, ov_c, om_c;
    logic [63:0] od_c;
    logic        ready_d, ov_d, om_d;
    logic [4:0]  od_d;

    gray_bin_conv_pipe #(.WIDTH(8), .STAGES(3)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .in_mode(in_mode_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .out_mode(out_mode_a));

    gray_bin_conv_pipe #(.WIDTH(4), .STAGES(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(e_valid), .in_ready(ready_b),
        .in_data(e_data[3:0]), .in_mode(e_mode), .out_valid(ov_b),
        .out_ready(1'b1), .out_data(od_b), .out_mode(om_b));

    gray_bin_conv_pipe #(.WIDTH(64), .STAGES(64)) u_c (
        .clk(clk), .rst(rst), .in_valid(e_valid), .in_ready(ready_c),
        .in_data(e_data), .in_mode(e_mode), .out_valid(ov_c),
        .out_ready(1'b1), .out_data(od_c), .out_mode(om_c));

    gray_bin_conv_pipe #(.WIDTH(5), .STAGES(1)) u_d (
        .clk(clk), .rst(rst), .in_valid(e_valid), .in_ready(ready_d),
        .in_data(e_data[4:0]), .in_mode(e_mode), .out_valid(ov_d),
        .out_ready(1'b1), .out_data(od_d), .out_mode(om_d));

    // Reference: binary bit i is the parity of all Gray bits at or above i.
    function automatic logic [63:0] model(input logic [63:0] d, input logic m, input int w);
        logic [63:0] x;
        logic [63:0] r;
        x = (w >= 64) ? d : (d & ((64'd1 << w) - 64'd1));
        r = 64'h0;
        if (m) r = x ^ (x >> 1);
        else for (int i = 0; i < 64; i++) r[i] = ^(x >> i);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output-ready pattern for the main DUT: 0 = always, 1 = random, 2 = held low
    int bp = 0;
    always @(posedge clk) begin
        #1;
        case (bp)
            0:       out_ready_a = 1'b1;
            1:       out_ready_a = 1'($urandom_range(0, 1));
            default: out_ready_a = 1'b0;
        endcase
    end

    // Scoreboard for the main DUT, evaluated mid-cycle for the coming edge
    typedef struct { int cyc; logic mode; logic [7:0] d; } exp_t;
    exp_t        exp_q[$];
    exp_t        e;
    int          cyc = 0;
    int          n_push = 0;
    int          n_pop = 0;
    bit          lat_strict = 1'b1;
    logic        held_vld = 1'b0;
    logic [7:0]  held_data;
    logic        held_mode;
    logic [63:0] tmp;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held_vld = 1'b0;
        end else begin
            cyc++;
            if (held_vld) begin
                chk("stall_valid", out_valid_a, 1'b1);
                chk("stall_data", out_data_a, held_data);
                chk("stall_mode", out_mode_a, held_mode);
            end
            chk("in_ready_rule", in_ready_a, (exp_q.size() < 3) || out_ready_a);
            if (exp_q.size() == 0) chk("empty_out_valid", out_valid_a, 1'b0);
            if (out_valid_a && out_ready_a) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", out_valid_a, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    n_pop++;
                    chk("out_data", out_data_a, e.d);
                    chk("out_mode", out_mode_a, e.mode);
                    if (lat_strict) chk("latency", cyc - e.cyc, 3);
                    else chk("latency_min", (cyc - e.cyc) >= 3, 1'b1);
                end
            end
            held_vld  = out_valid_a && !out_ready_a;
            held_data = out_data_a;
            held_mode = out_mode_a;
            if (in_valid_a && in_ready_a) begin
                tmp = model({56'h0, in_data_a}, in_mode_a, 8);
                exp_q.push_back('{cyc: cyc, mode: in_mode_a, d: tmp[7:0]});
                n_push++;
            end
        end
    end

    task automatic send_a(input logic [7:0] d, input logic m, output int waits);
        logic acc;
        acc   = 1'b0;
        waits = 0;
        in_valid_a = 1'b1;
        in_data_a  = d;
        in_mode_a  = m;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready_a;
            @(posedge clk);
            #1;
            if (!acc) begin
                waits++;
                if (waits > 200) begin
                    chk("send_timeout", 1'b1, 1'b0);
                    acc = 1'b1;
                end
            end
        end
        in_valid_a = 1'b0;
    endtask

    logic [63:0] last_b;

    // One beat into the edge instances; c counts edges from the accepting edge.
    task automatic probe(input logic [63:0] d, input logic m);
        chk("edge_in_ready", {61'h0, ready_b, ready_c, ready_d}, 64'h7);
        e_valid = 1'b1;
        e_data  = d;
        e_mode  = m;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) e_valid = 1'b0;
            chk("lat_w4s2", ov_b, c == 2);
            chk("lat_w64s64", ov_c, c == 64);
            chk("lat_w5s1", ov_d, c == 1);
            if (c == 2) begin
                chk("w4_data", od_b, model(d, m, 4));
                chk("w4_mode", om_b, m);
                last_b = {60'h0, od_b};
            end
            if (c == 64) begin
                chk("w64_data", od_c, model(d, m, 64));
                chk("w64_mode", om_c, m);
            end
            if (c == 1) begin
                chk("w5_data", od_d, model(d, m, 5));
                chk("w5_mode", om_d, m);
            end
        end
    endtask

    int          w;
    int          total_w;
    logic [7:0]  rd;
    logic        rm;
    logic [63:0] rv;
    logic [9:0]  jj;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready_a, 1'b0);
        chk("rst_out_valid", out_valid_a, 1'b0);
        chk("rst_out_data", out_data_a, 8'h00);
        chk("rst_edge_ready", {61'h0, ready_b, ready_c, ready_d}, 64'h0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", in_ready_a, 1'b1);

        // Pin the reference model with hand-computed values
        chk("pin_g2b_0110", model(64'h6, MODE_G2B, 4), 64'h4);
        chk("pin_g2b_1000", model(64'h8, MODE_G2B, 4), 64'hF);
        chk("pin_b2g_1011", model(64'hB, MODE_B2G, 4), 64'hE);
        chk("pin_g2b_80", model(64'h80, MODE_G2B, 8), 64'hFF);
        chk("pin_pkg_ref", g2b_ref(64'h80), 64'hFF);
        @(posedge clk);
        #1;

        // Basic directed beats on WIDTH=4/STAGES=2, also run through the edge shapes
        probe(64'h6, MODE_G2B);
        chk("basic_g2b_0110", last_b, 64'h4);
        probe(64'h8, MODE_G2B);
        chk("basic_g2b_1000", last_b, 64'hF);
        probe(64'hB, MODE_B2G);
        chk("basic_b2g_1011", last_b, 64'hE);
        for (int m = 0; m < 2; m++) begin
            probe(64'h0, 1'(m));
            probe(64'hFFFF_FFFF_FFFF_FFFF, 1'(m));
            probe(64'h1, 1'(m));
            probe(64'h10, 1'(m));
            probe(64'h8000_0000_0000_0000, 1'(m));
        end
        for (int i = 0; i < 4; i++) begin
            rv = {32'($urandom), 32'($urandom)};
            probe(rv, 1'(i));
        end

        // Exhaustive interleaved streaming, out_ready held high
        total_w = 0;
        for (int j = 0; j < 512; j++) begin
            jj = 10'(j);
            send_a(jj[8:1], jj[0], w);
            total_w += w;
        end
        chk("stream_throughput_stalls", total_w, 0);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("stream_drained", exp_q.size(), 0);

        // Random back-pressure
        lat_strict = 1'b0;
        bp = 1;
        for (int j = 0; j < 1000; j++) begin
            rd = 8'($urandom);
            rm = 1'($urandom);
            send_a(rd, rm, w);
        end
        bp = 0;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("bp_drained", exp_q.size(), 0);
        chk("beats_delivered", n_pop, 1512);
        repeat (2) @(posedge clk);
        #1;
        lat_strict = 1'b1;

        // Reset with beats in flight
        bp = 2;
        repeat (2) @(posedge clk);
        #1;
        send_a(8'h3C, MODE_B2G, w);
        send_a(8'h5A, MODE_G2B, w);
        @(posedge clk);
        #2;
        chk("pre_reset_valid", out_valid_a, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid_a, 1'b0);
        chk("async_rst_data", out_data_a, 8'h00);
        chk("async_rst_mode", out_mode_a, 1'b0);
        chk("async_rst_ready", in_ready_a, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        bp = 0;
        @(posedge clk);
        #1;
        send_a(8'h80, MODE_G2B, w);
        for (int k = 0; k < 10 && !out_valid_a; k++) begin
            @(posedge clk);
            #1;
        end
        chk("post_reset_valid", out_valid_a, 1'b1);
        chk("post_reset_g2b_80", out_data_a, 8'hFF);
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
